// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 five-stage pipeline control: hazard stall/bubble generation, run/halt
// state machine and saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic [2:0]       cpu_stat,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t state, state_nxt;
    logic   lu, rt, mp, mx, wx;

    assign lu = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && (E_dstM != R_NONE)
                && (E_dstM == d_srcA || E_dstM == d_srcB);
    assign rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mp = (E_icode == I_JXX) && !e_Cnd;
    assign mx = (m_stat == STAT_HLT) || (m_stat == STAT_ADR) || (m_stat == STAT_INS);
    assign wx = (W_stat == STAT_HLT) || (W_stat == STAT_ADR) || (W_stat == STAT_INS);

    assign halted = (state == S_HALTED);

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        F_stall   = 1'b1;
        D_stall   = 1'b1;
        D_bubble  = 1'b0;
        E_bubble  = 1'b1;
        M_bubble  = 1'b1;
        W_stall   = 1'b1;
        set_cc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) state_nxt = S_RUN;
            end
            S_RUN: begin
                F_stall  = lu | rt;
                D_stall  = lu;
                D_bubble = mp | (!lu & rt);
                E_bubble = mp | lu;
                M_bubble = mx | wx;
                W_stall  = wx;
                set_cc   = (E_icode == I_OPQ) & !mx & !wx;
                if (wx) state_nxt = S_HALTED;
            end
            default: ;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cpu_stat <= STAT_AOK;
        end else begin
            state <= state_nxt;
            if (state == S_RUN && wx) cpu_stat <= W_stat;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != '1) ? v + CNT_W'(1) : v;
    endfunction

    // Counters only advance while running; they saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
            lu_cnt  <= '0;
            mp_cnt  <= '0;
        end else if (state == S_RUN) begin
            cyc_cnt <= sat_inc(cyc_cnt, 1'b1);
            ret_cnt <= sat_inc(ret_cnt, W_stat == STAT_AOK);
            lu_cnt  <= sat_inc(lu_cnt, lu);
            mp_cnt  <= sat_inc(mp_cnt, mp);
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the Y86-64 five-stage pipeline. Combinationally derives per-stage stall/bubble and condition-code-update controls from decode, execute, memory and writeback state. It also runs a run/halt state machine that freezes the pipeline before start and after an exception or halt retires. Saturating performance counters record cycles, retired instructions, load/use stalls and branch mispredicts.

## Interface
- CNT_W, 32, width of each performance counter
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- go  in  1  one-cycle start pulse; honoured only in IDLE
- D_icode  in  4  icode in D register
- d_srcA, d_srcB  in  4 each  decode source register IDs (0xF = none)
- E_icode  in  4  icode in E register
- E_dstM  in  4  memory destination in E register
- e_Cnd  in  1  branch/cmov condition computed in execute
- M_icode  in  4  icode in M register
- m_stat  in  3  status produced by memory stage
- W_stat  in  3  status in W register (0 BUB, 1 AOK, 2 HLT, 3 ADR, 4 INS)
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  out  1 each  pipeline-register controls
- set_cc  out  1  enable CC write in execute
- cpu_stat  out  3  architectural status (registered)
- halted  out  1  state == HALTED
- cyc_cnt, ret_cnt, lu_cnt, mp_cnt  out  CNT_W each  cycles in RUN, retired instructions, load/use stalls, mispredicts

## Operation
- Hazard terms, computed combinationally every cycle:
  - lu = E_icode ∈ {5 MRMOVQ, B POPQ}, E_dstM != 0xF, and E_dstM ∈ {d_srcA, d_srcB}.
  - rt = 9 RET ∈ {D_icode, E_icode, M_icode}.
  - mp = E_icode == 7 JXX and !e_Cnd.
  - mx = m_stat ∈ {2,3,4}.
  - wx = W_stat ∈ {2,3,4}.
- Outputs in RUN:
  - F_stall = lu | rt
  - D_stall = lu
  - D_bubble = mp | (!lu & rt)
  - E_bubble = mp | lu
  - M_bubble = mx | wx
  - W_stall = wx
  - set_cc = (E_icode == 6 OPQ) & !mx & !wx
- Outputs in IDLE and HALTED, regardless of inputs:
  - F_stall = D_stall = W_stall = 1
  - E_bubble = M_bubble = 1
  - D_bubble = 0, set_cc = 0
- States: IDLE → RUN on go; RUN → HALTED on wx; HALTED is left only by reset. go outside IDLE is ignored.
- cpu_stat:
  - 1 (AOK) in IDLE and RUN.
  - On the RUN→HALTED edge, latches W_stat and holds it.
  - W_stat = 0 (BUB) never changes cpu_stat.
- Counters, active in RUN only:
  - cyc_cnt increments every RUN cycle.
  - ret_cnt increments when W_stat == 1.
  - lu_cnt increments when lu.
  - mp_cnt increments when mp.
  - All counters saturate at 2^CNT_W−1 with no wrap. All hold in IDLE/HALTED.
- Simultaneous hazards:
  - lu with RET in D: D_stall=1, D_bubble=0. Stall wins over bubble.
  - mp with rt: F_stall=1, D_bubble=1, E_bubble=1.
  - lu and mp cannot coexist, since E holds a single icode.

## Timing
- Control outputs are combinational from current inputs plus registered state: zero-cycle latency, sampled by the pipeline registers at the same edge.
- State, cpu_stat and counters update on the rising clk edge.
- The cycle where wx first holds is still RUN: W_stall=1 and M_bubble=1 are asserted combinationally, ret_cnt does not count, and cyc_cnt counts. From the next cycle the block is HALTED with frozen outputs.
- go at the same edge as rst_n deassertion is ignored; go must arrive at a later rising edge. The first RUN cycle is the cycle after go is sampled.
- Reset (asynchronous, any state or mid-run):
  - state = IDLE, cpu_stat = 1, all counters = 0, halted = 0.
  - Control outputs immediately take IDLE values.

## Test plan
- Reset/start: rst_n low with go=1 → IDLE outputs (F_stall=1, E_bubble=1), cpu_stat=1, counters 0. Release reset, pulse go one cycle → next cycle F_stall=0 (with no hazard inputs) and cyc_cnt begins 1, 2, 3.
- Load/use: RUN, E_icode=5, E_dstM=3, d_srcB=3 → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; lu_cnt +1 per cycle held. E_dstM=0xF → all four drop to 0.
- Mispredict: E_icode=7, e_Cnd=0 → D_bubble=1, E_bubble=1, F_stall=0, mp_cnt +1. e_Cnd=1 → no bubbles.
- RET sequencing: D_icode=9 for 1 cycle, then E_icode=9, then M_icode=9 → F_stall=1 and D_bubble=1 for 3 cycles. Same with lu asserted → D_stall=1, D_bubble=0.
- Halt/exception:
  - m_stat=3 → M_bubble=1 and set_cc=0 with E_icode=6.
  - Next W_stat=3 → W_stall=1; following cycle halted=1, cpu_stat=3, counters frozen.
  - go pulse → no change.
  - W_stat=0 with m_stat=1 → cpu_stat stays 1, ret_cnt unchanged.
- Saturation/reset: CNT_W=4, run 20 cycles → cyc_cnt=15 and holds. Assert rst_n low mid-run → counters 0 and state IDLE asynchronously, before the next clk edge.
